// File: rtl/mdac_pkg.sv
// Shared types and defaults for the mdac shift-add multiplier.
// Optional macro: MDAC_SIGNED_EN (two's complement operands).
package mdac_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult_if.sv
// start/busy/done handshake and operand/product bus of the multiplier.
// Optional macro: MDAC_SIGNED_EN (operands read as two's complement).
interface shift_add_mult_if
    import mdac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/mdac_reg_en.sv
// Load-enabled register with asynchronous active-low clear.
// Optional macro: MDAC_SIGNED_EN (no effect on this block).
module mdac_reg_en #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Optional macro: MDAC_SIGNED_EN (signed operands via magnitude + sign).
module shift_add_mult
    import mdac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    shift_add_mult_if.slave bus
);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic                 acc_en;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   prod_d;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;
    logic                 accept;
    logic                 last;

    assign accept = (state_q == IDLE) && bus.start;
    assign last   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // Carry lands in the top bit of sum and is shifted straight back in.
    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end
    end

    assign shifted = {sum, acc_q[WIDTH-1:1]};

`ifdef MDAC_SIGNED_EN
    logic sign_q;

    assign op_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign op_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q <= 1'b0;
        end else if (accept) begin
            sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
    end

    assign prod_d = sign_q ? -shifted : shifted;
`else
    assign op_a   = bus.a;
    assign op_b   = bus.b;
    assign prod_d = shifted;
`endif

    assign acc_d  = accept ? {{WIDTH{1'b0}}, op_b} : shifted;
    assign acc_en = accept || (state_q == RUN);

    mdac_reg_en #(.W(WIDTH)) u_mcand (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .d       (op_a),
        .q       (mcand_q)
    );

    mdac_reg_en #(.W(2*WIDTH)) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (acc_en),
        .d       (acc_d),
        .q       (acc_q)
    );

    mdac_reg_en #(.W(2*WIDTH)) u_prod (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (last),
        .d       (prod_d),
        .q       (prod_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (WIDTH=8) against a plain multiply.
// Optional macro: MDAC_SIGNED_EN selects the signed reference and vectors.
module tb_shift_add_mult;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    shift_add_mult_if #(.WIDTH(W)) bus ();

    shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int p;
`ifdef MDAC_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'(a) * int'(b);
`endif
        return p[2*W-1:0];
    endfunction

    // Issues one operation from IDLE; returns at the sample after done rises.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int busy_cnt, output int done_at);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        busy_cnt  = 0;
        done_at   = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                done_at = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b product=%h want 0 0 0000",
                     bus.busy, bus.done, bus.product);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   va [3];
        logic [W-1:0]   vb [3];
        logic [2*W-1:0] ve [3];
        int bc, da;
`ifdef MDAC_SIGNED_EN
        va = '{8'hFD, 8'h80, 8'h7F};
        vb = '{8'h05, 8'h80, 8'hFF};
        ve = '{16'hFFF1, 16'h4000, 16'hFF81};
`else
        va = '{8'd13, 8'd255, 8'd0};
        vb = '{8'd11, 8'd255, 8'd200};
        ve = '{16'h008F, 16'hFE01, 16'h0000};
`endif
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], bc, da);
            n_tests++;
            if (da !== 8 || bc !== 8) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: busy=%0d done_at=%0d want 8 8",
                         i, bc, da);
            end
            n_tests++;
            if (bus.product !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_product[%0d]: got %h want %h",
                         i, bus.product, ve[i]);
            end
            @(posedge clk); #1;
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_after[%0d]: done=%b busy=%b product=%h want 0 0 %h",
                         i, bus.done, bus.busy, bus.product, ve[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b;
        logic [2*W-1:0] exp;
        int bc, da, idle;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (i == 0) a = '0;
            if (i == 1) b = '0;
            if (i == 2) begin a = '1; b = '1; end
            if (i == 3) begin a = 8'h80; b = 8'h01; end
            exp = ref_mul(a, b);
            do_op(a, b, bc, da);
            n_tests++;
            if (da !== 8 || bus.product !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] %h*%h: product=%h done_at=%0d want %h 8",
                         i, a, b, bus.product, da, exp);
            end
            idle = int'($urandom_range(3, 1));
            repeat (idle) begin
                @(posedge clk); #1;
            end
            n_tests++;
            if (bus.product !== exp || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_hold[%0d]: product=%h busy=%b want %h 0",
                         i, bus.product, bus.busy, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, da, seen_change;
        bus.start = 1'b1;
        bus.a     = 8'd13;
        bus.b     = 8'd11;
        @(posedge clk); #1;
        bus.a = 8'd2;
        bus.b = 8'd3;
        da = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                da = k;
                break;
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (da !== 8 || bus.product !== 16'h008F) begin
            n_fail++;
            $display("FAIL b2b_first: product=%h done_at=%0d want 008F 8",
                     bus.product, da);
        end
        // start is still high across the DONE cycle and must be ignored.
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ignored: busy=%b done=%b want 0 0",
                     bus.busy, bus.done);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (bus.product !== 16'h008F || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_hold: product=%h busy=%b want 008F 0",
                     bus.product, bus.busy);
        end
        bus.start = 1'b1;
        bus.a     = 8'd2;
        bus.b     = 8'd3;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        seen_change = 0;
        da          = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                da = k;
                break;
            end
            if (bus.product !== 16'h008F) seen_change++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen_change != 0) begin
            n_fail++;
            $display("FAIL b2b_run_hold: product moved %0d times during run, want 0",
                     seen_change);
        end
        n_tests++;
        if (da !== 8 || bus.product !== 16'h0006) begin
            n_fail++;
            $display("FAIL b2b_second: product=%h done_at=%0d want 0006 8",
                     bus.product, da);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int stray;
        bus.start = 1'b1;
        bus.a     = 8'd13;
        bus.b     = 8'd11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%h want 0 0 0000",
                     bus.busy, bus.done, bus.product);
        end
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        stray   = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0 || bus.product !== '0) begin
            n_fail++;
            $display("FAIL midrun_release: %0d busy/done cycles product=%h want 0 0000",
                     stray, bus.product);
        end
        bc_after_reset();
    endtask

    task automatic bc_after_reset();
        int bc, da;
        do_op(8'd7, 8'd9, bc, da);
        n_tests++;
        if (da !== 8 || bus.product !== ref_mul(8'd7, 8'd9)) begin
            n_fail++;
            $display("FAIL post_reset_op: product=%h done_at=%0d want %h 8",
                     bus.product, da, ref_mul(8'd7, 8'd9));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
